muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide instructions.
- Sits in the execute stage beside the single-cycle ALU and decodes the same control fields (ALUOp, Funct7, Funct3).
- For M-extension ops it stalls the pipeline and runs a shift-add multiply or a restoring divide. It then presents the result for one cycle.
- Non-M ops pass untouched and take no cycles.

---
 rtl/muldiv_sequencer.sv | 153 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer. It runs shift-add multiply and restoring divide beside the single-cycle ALU.
// It stalls the pipeline while busy and pulses done for one cycle with Result.
module muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic [1:0]            ALUOp,
    input  logic [6:0]            Funct7,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

    state_t        state;
    logic [W-1:0]  op_a, op_b, mcand, hi, lo;
    logic [2:0]    fn;
    logic          neg;
    logic [CW-1:0] count;

    logic is_m;
    assign is_m  = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
    assign stall = ((state == IDLE) && valid_in && is_m && !flush) ||
                   (state == PREP) || (state == CALC) || (state == FIXUP);

    // Operand signedness, magnitudes and the special divide cases
    logic         is_div, a_signed, b_signed, sign_a, sign_b, div_zero, div_ovf, neg_next;
    logic [W-1:0] mag_a, mag_b, min_val;
    always_comb begin
        is_div   = fn[2];
        a_signed = (fn == 3'b001) || (fn == 3'b010) || (fn == 3'b100) || (fn == 3'b110);
        b_signed = (fn == 3'b001) || (fn == 3'b100) || (fn == 3'b110);
        sign_a   = a_signed && op_a[W-1];
        sign_b   = b_signed && op_b[W-1];
        mag_a    = sign_a ? (~op_a + W'(1)) : op_a;
        mag_b    = sign_b ? (~op_b + W'(1)) : op_b;
        min_val  = {1'b1, {(W-1){1'b0}}};
        div_zero = is_div && (op_b == {W{1'b0}});
        div_ovf  = is_div && !fn[0] && (op_a == min_val) && (op_b == {W{1'b1}});
        // remainder takes the dividend's sign, everything else the xor
        neg_next = (is_div && fn[1]) ? sign_a : (sign_a ^ sign_b);
    end

    // One multiply or divide step on {hi, lo}
    logic [W-1:0] addend;
    logic [W:0]   add_sum, trial;
    always_comb begin
        addend  = lo[0] ? mcand : {W{1'b0}};
        add_sum = {1'b0, hi} + {1'b0, addend};
        trial   = {hi, lo[W-1]} - {1'b0, mcand};
    end

    // Sign correction and word selection
    logic [PW-1:0] prod, prod_s;
    logic [W-1:0]  quot_s, rem_s, final_val;
    always_comb begin
        prod   = {hi, lo};
        prod_s = neg ? (~prod + PW'(1)) : prod;
        quot_s = neg ? (~lo + W'(1)) : lo;
        rem_s  = neg ? (~hi + W'(1)) : hi;
        case (fn)
            3'b000:                 final_val = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_s[PW-1:W];
            3'b100, 3'b101:         final_val = quot_s;
            default:                final_val = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            done   <= 1'b0;
            Result <= '0;
            op_a   <= '0;
            op_b   <= '0;
            fn     <= '0;
            neg    <= 1'b0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in && is_m && !flush) begin
                        op_a  <= SrcA;
                        op_b  <= SrcB;
                        fn    <= Funct3;
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (div_zero) begin
                        Result <= fn[1] ? op_a : {W{1'b1}};
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (div_ovf) begin
                        Result <= fn[1] ? {W{1'b0}} : min_val;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        neg   <= neg_next;
                        mcand <= is_div ? mag_b : mag_a;
                        lo    <= is_div ? mag_a : mag_b;
                        hi    <= '0;
                        count <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            // restoring step: keep the difference only when it did not borrow
                            hi <= trial[W] ? {hi[W-2:0], lo[W-1]} : trial[W-1:0];
                            lo <= {lo[W-2:0], ~trial[W]};
                        end else begin
                            hi <= add_sum[W:1];
                            lo <= {add_sum[0], lo[W-1:1]};
                        end
                        count <= count + CW'(1);
                        if (count == CW'(W - 1)) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        Result <= final_val;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver queues expected results and due cycles.
// A negedge monitor checks every done pulse against the queue.
module tb_muldiv_sequencer;
    localparam int unsigned W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n, valid_in, flush;
    logic [1:0]   ALUOp;
    logic [6:0]   Funct7;
    logic [2:0]   Funct3;
    logic [W-1:0] SrcA, SrcB, Result;
    logic         stall, done;

    muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .stall(stall), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int unsigned  due;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           passes = 0;
    int           stall_cycles = 0;
    logic [W-1:0] last_exp = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference model built on 64-bit integer arithmetic
    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sbv, ub;
        logic [63:0]  p;
        logic [W-1:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ub  = longint'({32'b0, b});
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0];  end
            3'd1: begin p = 64'(sa * sbv);            r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub);             r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? '1 : ((a == MINV && b == '1) ? MINV : 32'(sa / sbv));
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: r = (b == 0) ? a : ((a == MINV && b == '1) ? '0 : 32'(sa % sbv));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == MINV && b == '1));
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return MINV;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (stall) stall_cycles++;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, Result, e.res);
                check({e.name, "_done_cycle"}, cyc, e.due);
            end
        end
    end

    // Present an M op for one accept cycle; then wiggle inputs while busy to show they are ignored
    task automatic issue(input string name, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expv, input bit push, output int unsigned acc);
        exp_t e;
        bit   fast;
        fast = is_fast(f, a, b);
        @(posedge clk); #1;
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f; SrcA = a; SrcB = b; valid_in = 1'b1;
        acc = cyc;
        if (push) begin
            e.res = expv; e.due = cyc + (fast ? 2 : W + 3); e.name = name;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if (!fast) begin
            for (int i = 0; i < 3; i++) begin
                Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
                @(posedge clk); #1;
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        last_exp = Result === 'x ? '0 : last_exp;
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expv);
        int unsigned acc;
        issue(name, f, a, b, expv, 1'b1, acc);
        drain();
        last_exp = expv;
    endtask

    task automatic wait_cycle(input int unsigned target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned  acc, d;
        logic [2:0]   f;
        logic [W-1:0] a, b;

        rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0;
        ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_result", Result, 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        #1 rst_n = 1'b1;

        // MUL with stall window count
        @(posedge clk); #1; stall_cycles = 0;
        run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        check("mul_stall_cycles", 32'(stall_cycles), 32'(W + 3));

        run("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
        run("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run("divu",   3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
        run("remu",   3'd7, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001);
        run("div_by_zero",  3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run("remu_by_zero", 3'd7, 32'd5, 32'd0, 32'h0000_0005);
        run("div_overflow", 3'd4, MINV, 32'hFFFF_FFFF, MINV);
        run("rem_overflow", 3'd6, MINV, 32'hFFFF_FFFF, 32'd0);

        // Non-M instructions pass without stalling
        @(posedge clk); #1;
        ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'd0; valid_in = 1'b1;
        @(negedge clk);
        check("add_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ALUOp = 2'b01; Funct7 = 7'b0000001;
        @(negedge clk);
        check("branch_stall", 32'(stall), 32'd0);
        @(posedge clk); #1; valid_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("non_m_idle_stall", 32'(stall), 32'd0);
        check("non_m_result_kept", Result, last_exp);

        // flush together with a valid M op in IDLE blocks the accept
        @(posedge clk); #1;
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
        valid_in = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1; valid_in = 1'b0; flush = 1'b0;
        repeat (40) @(posedge clk);

        // Back-to-back: MUL, then DIVU accepted the cycle after DONE
        issue("b2b_mul", 3'd0, 32'd12345, 32'd678, 32'd8369910, 1'b1, acc);
        d = 0;
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        issue("b2b_divu", 3'd5, 32'd1000, 32'd7, 32'd142, 1'b1, acc);
        drain();
        last_exp = 32'd142;

        // flush 10 cycles into CALC: no done, Result untouched
        issue("flushed", 3'd0, 32'd99, 32'd99, '0, 1'b0, acc);
        wait_cycle(acc + 12);
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall_before", 32'(stall), 32'd1);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        check("flush_stall_after", 32'(stall), 32'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("flush_result_kept", Result, last_exp);

        // flush in the DONE cycle is ignored
        issue("flush_in_done", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, acc);
        wait_cycle(acc + 2);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        drain();
        last_exp = 32'hFFFF_FFFF;
        @(negedge clk);
        check("flush_in_done_result", Result, last_exp);

        // Reset in the middle of an op
        issue("reset_mid", 3'd1, 32'd77, 32'd88, '0, 1'b0, acc);
        wait_cycle(acc + 20);
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("midreset_result", Result, 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_stall", 32'(stall), 32'd0);
        last_exp = '0;
        repeat (40) @(posedge clk);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run($sformatf("rand%0d_f%0d", i, f), f, a, b, model(f, a, b));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
